gru_hidden_update: RTL and testbench

Final GRU stage. It consumes per-element candidate values n_t[i] from the new-gate elements and update-gate values z_t[i]. It computes h_t[i] = n_t[i] + z_t[i]·(h_prev[i] − n_t[i]) in Q(DATA_WIDTH−FRAC_BITS).FRAC_BITS fixed point, collects all H results in a shadow buffer, then commits them atomically. The committed vector is the h_t_prev operand for the next timestep's gate elements.

---
 rtl/gru_hidden_update_if.sv | 17 +
 rtl/gru_hidden_update.sv | 169 ++++++++++++++++
 tb/tb_gru_hidden_update.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gru_hidden_update_if.sv
// Element input channel for gru_hidden_update.
// Handshake: an element transfers on a rising clk edge where in_valid && in_ready.
// Once in_valid is raised, the master holds in_idx/n_t_in/z_t_in stable until that
// transfer. in_ready never depends on in_valid in the same cycle.
interface gru_hidden_update_if #(
    parameter int IDXW       = 8,
    parameter int DATA_WIDTH = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic [IDXW-1:0]              in_idx;
    logic signed [DATA_WIDTH-1:0] n_t_in;
    logic signed [DATA_WIDTH-1:0] z_t_in;

    modport master (output in_valid, in_idx, n_t_in, z_t_in, input in_ready);
    modport slave  (input in_valid, in_idx, n_t_in, z_t_in, output in_ready);
endinterface

// File: rtl/gru_hidden_update.sv
// gru_hidden_update: h_t[i] = n + z*(h_prev[i] - n) in fixed point, collected in a
// shadow buffer and committed to h_t atomically once all H elements are written.
// Optional macro GRU_HUPDATE_SAT_EN: saturate results instead of wrapping them.
module gru_hidden_update #(
    parameter int H          = 256,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int IDXW       = $clog2(H)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_state,
    gru_hidden_update_if.slave           in_if,
    output logic [H-1:0][DATA_WIDTH-1:0] h_t,
    output logic                         h_valid,
    output logic                         busy,
    output logic                         err_flag,
    output logic [1:0]                   state_dbg
);
    localparam int CW = IDXW + 1;
    localparam int PW = 2 * DATA_WIDTH + 1;
    localparam logic [CW-1:0] H_C = CW'(H);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, COMMIT} state_t;
    state_t state, state_nxt;

    logic [H-1:0]                   bitmap;
    logic [H-1:0][DATA_WIDTH-1:0]   shadow;
    logic [CW-1:0]                  wr_cnt;
    logic [CW-1:0]                  pending;

    logic                           s1_valid;
    logic [IDXW-1:0]                s1_idx;
    logic signed [DATA_WIDTH-1:0]   s1_n, s1_z;
    logic                           s2_valid;
    logic [IDXW-1:0]                s2_idx;
    logic signed [DATA_WIDTH-1:0]   s2_n;
    logic signed [PW-1:0]           s2_prod;

    logic                           accept, out_of_range, dup_hit, good, last_unique;
    logic signed [DATA_WIDTH-1:0]   h_prev;
    logic signed [DATA_WIDTH:0]     diff;
    logic signed [PW-1:0]           prod;
    logic signed [DATA_WIDTH-1:0]   res;

    assign in_if.in_ready = ((state == IDLE) || (state == COLLECT)) && !clear_state;
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign busy           = (state != IDLE) || s1_valid || s2_valid;
    assign state_dbg      = state;

    // Classify the offered element; duplicates also cover entries still in the pipeline.
    always_comb begin
        out_of_range = ({1'b0, in_if.in_idx} >= H_C);
        dup_hit      = (!out_of_range && bitmap[in_if.in_idx])
                     || (s1_valid && (s1_idx == in_if.in_idx))
                     || (s2_valid && (s2_idx == in_if.in_idx));
        good         = accept && !out_of_range && !dup_hit;
        pending      = wr_cnt + CW'(s1_valid) + CW'(s2_valid);
        last_unique  = good && ((pending + CW'(1)) == H_C);
    end

    // Stage 1 arithmetic: blend against the committed state, never the shadow.
    always_comb begin
        h_prev = h_t[s1_idx];
        diff   = {h_prev[DATA_WIDTH-1], h_prev} - {s1_n[DATA_WIDTH-1], s1_n};
        prod   = {{(DATA_WIDTH+1){s1_z[DATA_WIDTH-1]}}, s1_z}
               * {{DATA_WIDTH{diff[DATA_WIDTH]}}, diff};
    end

`ifdef GRU_HUPDATE_SAT_EN
    localparam logic signed [PW:0] SAT_MAX = {{(PW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN = {{(PW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    logic signed [PW-1:0] shifted;
    logic signed [PW:0]   sum;

    // Stage 2 result, clamped to the representable word range.
    always_comb begin
        shifted = s2_prod >>> FRAC_BITS;
        sum     = {shifted[PW-1], shifted}
                + {{(PW+1-DATA_WIDTH){s2_n[DATA_WIDTH-1]}}, s2_n};
        if (sum > SAT_MAX)      res = SAT_MAX[DATA_WIDTH-1:0];
        else if (sum < SAT_MIN) res = SAT_MIN[DATA_WIDTH-1:0];
        else                    res = sum[DATA_WIDTH-1:0];
    end
`else
    // Stage 2 result wraps to the low word bits.
    assign res = s2_n + DATA_WIDTH'(s2_prod >>> FRAC_BITS);
`endif

    // FSM next state: collection ends on the Hth unique accept, commit once drained.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = last_unique ? DRAIN : COLLECT;
            COLLECT: if (last_unique) state_nxt = DRAIN;
            DRAIN:   if (!s1_valid) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           state <= IDLE;
        else if (clear_state) state <= IDLE;
        else                  state <= state_nxt;
    end

    // Two-stage pipeline registers; dropped elements never enter stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_n     <= '0;
            s1_z     <= '0;
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            s2_n     <= '0;
            s2_prod  <= '0;
        end else if (clear_state) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= good;
            if (good) begin
                s1_idx <= in_if.in_idx;
                s1_n   <= in_if.n_t_in;
                s1_z   <= in_if.z_t_in;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_idx  <= s1_idx;
                s2_n    <= s1_n;
                s2_prod <= prod;
            end
        end
    end

    // Shadow writes, atomic commit, commit pulse and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_t      <= '0;
            shadow   <= '0;
            bitmap   <= '0;
            wr_cnt   <= '0;
            h_valid  <= 1'b0;
            err_flag <= 1'b0;
        end else if (clear_state) begin
            h_t      <= '0;
            shadow   <= '0;
            bitmap   <= '0;
            wr_cnt   <= '0;
            h_valid  <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            h_valid <= (state == COMMIT);
            if (accept && (out_of_range || dup_hit)) err_flag <= 1'b1;
            if (state == COMMIT) begin
                h_t    <= shadow;
                bitmap <= '0;
                wr_cnt <= '0;
            end else if (s2_valid) begin
                shadow[s2_idx] <= res;
                bitmap[s2_idx] <= 1'b1;
                wr_cnt         <= wr_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_gru_hidden_update.sv
// Self-checking bench for gru_hidden_update with H=4, Q8.8 words.
module tb_gru_hidden_update;
    localparam int H = 4;
    localparam int DW = 16;
`ifdef GRU_HUPDATE_SAT_EN
    localparam logic [DW-1:0] OVF_EXP = 16'h7FFF;
`else
    localparam logic [DW-1:0] OVF_EXP = 16'h7E00;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_state = 1'b0;
    always #5 clk = ~clk;

    gru_hidden_update_if #(.IDXW(2), .DATA_WIDTH(DW)) in_if ();
    logic [H-1:0][DW-1:0] h_t;
    logic h_valid, busy, err_flag;
    logic [1:0] state_dbg;

    gru_hidden_update #(.H(H), .DATA_WIDTH(DW), .FRAC_BITS(8), .IDXW(2)) dut (
        .clk(clk), .rst_n(rst_n), .clear_state(clear_state), .in_if(in_if),
        .h_t(h_t), .h_valid(h_valid), .busy(busy), .err_flag(err_flag),
        .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int hv_count = 0;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (h_valid === 1'b1) hv_count++;

    // scoreboard and reference model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_h[H];
    bit exp_err = 0;
    int stim_cnt;
    int stim_idx[16];
    logic [DW-1:0] stim_n[16];
    logic [DW-1:0] stim_z[16];
    int first_acc, last_acc;

    function automatic logic [DW-1:0] blend(input logic [DW-1:0] n, input logic [DW-1:0] z,
                                            input logic [DW-1:0] h);
        longint ln, lz, lh, r;
        ln = longint'($signed(n));
        lz = longint'($signed(z));
        lh = longint'($signed(h));
        r = ln + ((lz * (lh - ln)) >>> 8);
`ifdef GRU_HUPDATE_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return DW'(r);
    endfunction

    // driver tasks
    task automatic send(input int idx, input logic [DW-1:0] n, input logic [DW-1:0] z,
                        output int acc_cyc);
        bit ok;
        ok = 0;
        acc_cyc = -1;
        in_if.in_valid = 1'b1;
        in_if.in_idx = 2'(idx);
        in_if.n_t_in = n;
        in_if.z_t_in = z;
        for (int w = 0; w < 40; w++) begin
            if (in_if.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        in_if.in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout idx=%0d: in_ready stayed %b, required 1 within 40 cycles",
                     idx, in_if.in_ready);
        end
    endtask

    task automatic drive_stim(input bit gaps);
        int a;
        for (int i = 0; i < stim_cnt; i++) begin
            if (gaps && i > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
            send(stim_idx[i], stim_n[i], stim_z[i], a);
            if (i == 0) first_acc = a;
            last_acc = a;
        end
    endtask

    task automatic fill_all(input logic [DW-1:0] n, input logic [DW-1:0] z);
        stim_cnt = H;
        for (int i = 0; i < H; i++) begin
            stim_idx[i] = i;
            stim_n[i] = n;
            stim_z[i] = z;
        end
    endtask

    // One full timestep: model prediction, drive, latency and value checks.
    task automatic run_step(input string name, input bit gaps, input bit chk_after);
        logic [DW-1:0] nxt[H];
        bit seen[H];
        bit early;
        logic [DW-1:0] e;
        nxt = model_h;
        for (int i = 0; i < H; i++) seen[i] = 0;
        for (int i = 0; i < stim_cnt; i++) begin
            if (seen[stim_idx[i]]) exp_err = 1;
            else begin
                nxt[stim_idx[i]] = blend(stim_n[i], stim_z[i], model_h[stim_idx[i]]);
                seen[stim_idx[i]] = 1;
            end
        end
        for (int i = 0; i < H; i++) exp_q.push_back(nxt[i]);
        drive_stim(gaps);
        early = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (h_valid !== 1'b0) early = 1;
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL %s early_h_valid: h_valid=1 within 2 cycles of last accept, required 0", name);
        end
        @(negedge clk);
        n_checks++;
        if (h_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s h_valid_latency: h_valid=%b 3 cycles after last accept, required 1", name, h_valid);
        end
        for (int i = 0; i < H; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (h_t[i] !== e) begin
                n_fail++;
                $display("FAIL %s h_t[%0d]: got %h, required %h", name, i, h_t[i], e);
            end
        end
        n_checks++;
        if (err_flag !== exp_err) begin
            n_fail++;
            $display("FAIL %s err_flag: got %b, required %b", name, err_flag, exp_err);
        end
        model_h = nxt;
        if (chk_after) begin
            @(negedge clk);
            n_checks++;
            if (h_valid !== 1'b0 || in_if.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s after_commit: h_valid=%b in_ready=%b, required 0 and 1",
                         name, h_valid, in_if.in_ready);
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (h_t !== '0) begin n_fail++; $display("FAIL reset_h_t: got %h, required 0", h_t); end
        n_checks++;
        if (h_valid !== 1'b0) begin n_fail++; $display("FAIL reset_h_valid: got %b, required 0", h_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err_flag); end
        n_checks++;
        if (in_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_if.in_ready); end
    endtask

    task automatic test_basic_blend();
        fill_all(16'h0100, 16'h0080);
        run_step("basic_blend", 0, 1);
    endtask

    task automatic test_hold_pass();
        fill_all(16'h0040, 16'h0000);
        run_step("hold_setup", 0, 1);
        fill_all(16'h1234, 16'h0100);
        run_step("hold", 1, 1);
        fill_all(16'h0123, 16'h0000);
        run_step("pass_through", 0, 1);
    endtask

    task automatic test_dup_out_of_order();
        stim_cnt = 5;
        stim_idx[0] = 3; stim_n[0] = 16'h0303; stim_z[0] = 16'h0000;
        stim_idx[1] = 1; stim_n[1] = 16'h0101; stim_z[1] = 16'h0000;
        stim_idx[2] = 1; stim_n[2] = 16'h0BAD; stim_z[2] = 16'h0000;
        stim_idx[3] = 0; stim_n[3] = 16'h0A0A; stim_z[3] = 16'h0000;
        stim_idx[4] = 2; stim_n[4] = 16'h0202; stim_z[4] = 16'h0000;
        run_step("dup_out_of_order", 0, 1);
    endtask

    task automatic test_overflow();
        fill_all(16'h8000, 16'h0000);
        run_step("ovf_setup", 0, 1);
        fill_all(16'h7F00, 16'hFF00);
        run_step("overflow", 0, 1);
        n_checks++;
        if (h_t[0] !== OVF_EXP) begin
            n_fail++;
            $display("FAIL overflow_const: got %h, required %h", h_t[0], OVF_EXP);
        end
    endtask

    task automatic test_clear();
        int a, hv0;
        send(0, 16'h0111, 16'h0040, a);
        send(1, 16'h0222, 16'h0040, a);
        in_if.in_valid = 1'b1;
        in_if.in_idx = 2'd2;
        in_if.n_t_in = 16'h0333;
        in_if.z_t_in = 16'h0040;
        clear_state = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready: got %b, required 0", in_if.in_ready); end
        @(posedge clk);
        #1;
        clear_state = 1'b0;
        in_if.in_valid = 1'b0;
        hv0 = hv_count;
        @(negedge clk);
        n_checks++;
        if (h_t !== '0) begin n_fail++; $display("FAIL clear_h_t: got %h, required 0", h_t); end
        n_checks++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL clear_err: got %b, required 0", err_flag); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %b, required 0", busy); end
        repeat (6) @(negedge clk);
        n_checks++;
        if (hv_count !== hv0) begin n_fail++; $display("FAIL clear_no_h_valid: got %0d pulses, required 0", hv_count - hv0); end
        for (int i = 0; i < H; i++) model_h[i] = '0;
        exp_err = 0;
        stim_cnt = H;
        for (int i = 0; i < H; i++) begin
            stim_idx[i] = H - 1 - i;
            stim_n[i] = 16'($urandom);
            stim_z[i] = 16'($urandom);
        end
        run_step("after_clear", 1, 1);
    endtask

    task automatic test_async_reset();
        int hv0;
        stim_cnt = 5;
        stim_idx[0] = 0; stim_idx[1] = 1; stim_idx[2] = 1; stim_idx[3] = 2; stim_idx[4] = 3;
        for (int i = 0; i < 5; i++) begin
            stim_n[i] = 16'($urandom);
            stim_z[i] = 16'($urandom);
        end
        hv0 = hv_count;
        drive_stim(0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (h_t !== '0 || h_valid !== 1'b0 || busy !== 1'b0 || err_flag !== 1'b0 || in_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_outputs: h_t=%h h_valid=%b busy=%b err=%b in_ready=%b, required 0,0,0,0,1",
                     h_t, h_valid, busy, err_flag, in_if.in_ready);
        end
        #3 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (hv_count !== hv0) begin n_fail++; $display("FAIL async_reset_no_h_valid: got %0d pulses, required 0", hv_count - hv0); end
        n_checks++;
        if (in_if.in_ready !== 1'b1 || h_t !== '0) begin
            n_fail++;
            $display("FAIL async_reset_release: in_ready=%b h_t=%h, required 1 and 0", in_if.in_ready, h_t);
        end
        for (int i = 0; i < H; i++) model_h[i] = '0;
        exp_err = 0;
    endtask

    task automatic test_random();
        int p[H];
        int j, t;
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < H; i++) p[i] = i;
            for (int i = H - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = p[i]; p[i] = p[j]; p[j] = t;
            end
            stim_cnt = 0;
            for (int i = 0; i < H - 1; i++) begin
                stim_idx[stim_cnt++] = p[i];
                if ($urandom_range(0, 3) == 0) stim_idx[stim_cnt++] = p[$urandom_range(0, i)];
            end
            stim_idx[stim_cnt++] = p[H-1];
            for (int i = 0; i < stim_cnt; i++) begin
                stim_n[i] = 16'($urandom);
                stim_z[i] = 16'($urandom_range(0, 16'h01FF)) - 16'h0100;
            end
            run_step("random", 1, 1);
        end
    endtask

    task automatic test_back_to_back();
        int f1;
        fill_all(16'h0055, 16'h00C0);
        run_step("b2b_first", 0, 0);
        f1 = first_acc;
        for (int i = 0; i < H; i++) stim_n[i] = 16'($urandom);
        run_step("b2b_second", 0, 1);
        n_checks++;
        if (first_acc - f1 !== H + 3) begin
            n_fail++;
            $display("FAIL b2b_timestep: got %0d cycles, required %0d", first_acc - f1, H + 3);
        end
    endtask

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_idx = '0;
        in_if.n_t_in = '0;
        in_if.z_t_in = '0;
        for (int i = 0; i < H; i++) model_h[i] = '0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_blend();
        test_hold_pass();
        test_dup_out_of_order();
        test_overflow();
        test_clear();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 ns");
        $fatal(1, "watchdog expired");
    end
endmodule
